// File: rtl/onewire_master_rtl.sv
// rtl/onewire_master_rtl.sv - multi-channel 1-wire bus master: reset/presence and bit time slots
module onewire_master_rtl #(
    parameter int OWN   = 1,
    parameter int CDR_N = 50,
    parameter int CDR_O = 7
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     req_vld,
    output logic                                     req_rdy,
    input  logic                                     req_cmd,
    input  logic                                     req_dat,
    input  logic                                     req_ovd,
    input  logic [((OWN > 1) ? $clog2(OWN) : 1)-1:0] req_sel,
    output logic                                     rsp_vld,
    output logic                                     rsp_dat,
    output logic [OWN-1:0]                           owr_pull,
    input  logic [OWN-1:0]                           owr_i
);

    localparam int SW      = (OWN > 1) ? $clog2(OWN) : 1;
    localparam int CDR_MAX = (CDR_N > CDR_O) ? CDR_N : CDR_O;
    localparam int PW      = (CDR_MAX > 1) ? $clog2(CDR_MAX) : 1;

    localparam logic [PW-1:0] CDR_N_M1 = PW'(CDR_N - 1);
    localparam logic [PW-1:0] CDR_O_M1 = PW'(CDR_O - 1);

    // Slot timing in ticks (1 us normal speed)
    localparam logic [9:0] T_RST_LOW  = 10'd480;
    localparam logic [9:0] T_RST_SAMP = 10'd550;
    localparam logic [9:0] T_RST_END  = 10'd960;
    localparam logic [9:0] T_W0_LOW   = 10'd60;
    localparam logic [9:0] T_W1_LOW   = 10'd6;
    localparam logic [9:0] T_BIT_SAMP = 10'd15;
    localparam logic [9:0] T_BIT_END  = 10'd70;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic           cmd_q;
    logic           dat_q;
    logic [SW-1:0]  sel_q;
    logic [PW-1:0]  cdr_m1_q;
    logic [PW-1:0]  presc_q;
    logic [9:0]     t_q;
    logic [9:0]     t_nxt;
    logic           samp_q;
    logic [OWN-1:0] sync1_q;
    logic [OWN-1:0] sync2_q;

    logic           accept;
    logic           tick;
    logic [9:0]     low_lim;
    logic [9:0]     samp_pt;
    logic [9:0]     end_pt;
    logic [SW-1:0]  sel_cur;
    logic [OWN-1:0] onehot;
    logic           pad_bit;
    logic [OWN-1:0] pull_d;
    logic           rsp_vld_d;
    logic           rsp_dat_d;

    assign accept  = req_vld && (state_q == IDLE);
    assign tick    = (presc_q == cdr_m1_q);
    assign t_nxt   = t_q + 10'd1;
    assign low_lim = !cmd_q ? T_RST_LOW : (dat_q ? T_W1_LOW : T_W0_LOW);
    assign samp_pt = cmd_q ? T_BIT_SAMP : T_RST_SAMP;
    assign end_pt  = cmd_q ? T_BIT_END : T_RST_END;
    // While idle the pull target comes straight from the request so the pad drops the cycle after acceptance
    assign sel_cur = (state_q == IDLE) ? req_sel : sel_q;

    // Channel decode; an out-of-range index selects no channel
    always_comb begin
        onehot = '0;
        for (int i = 0; i < OWN; i++) begin
            if (sel_cur == SW'(i)) begin
                onehot[i] = 1'b1;
            end
        end
    end

    // Synchronized pad of the active channel; a missing channel reads as an idle (high) bus
    always_comb begin
        pad_bit = 1'b1;
        for (int i = 0; i < OWN; i++) begin
            if (sel_q == SW'(i)) begin
                pad_bit = sync2_q[i];
            end
        end
    end

    // Two-flop synchronizer per channel, idle-high at reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= owr_i;
            sync2_q <= sync1_q;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: phase boundaries are taken on the tick that brings t to the limit
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_vld) begin
                    state_d = LOW;
                end
            end
            LOW: begin
                if (tick && (t_nxt == low_lim)) begin
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (tick && (t_nxt == end_pt)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: ready decode and the values loaded into the registered pad/response outputs
    always_comb begin
        req_rdy   = (state_q == IDLE);
        pull_d    = (state_d == LOW) ? onehot : '0;
        rsp_vld_d = (state_q == HIGH) && (state_d == IDLE);
        rsp_dat_d = cmd_q ? samp_q : ~samp_q;
    end

    // Request latch, prescaler, tick counter and line sampling
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_q    <= 1'b0;
            dat_q    <= 1'b0;
            sel_q    <= '0;
            cdr_m1_q <= '0;
            presc_q  <= '0;
            t_q      <= '0;
            samp_q   <= 1'b1;
        end else if (accept) begin
            cmd_q    <= req_cmd;
            dat_q    <= req_dat;
            sel_q    <= req_sel;
            cdr_m1_q <= req_ovd ? CDR_O_M1 : CDR_N_M1;
            presc_q  <= '0;
            t_q      <= '0;
        end else if (state_q != IDLE) begin
            if (tick) begin
                presc_q <= '0;
                t_q     <= t_nxt;
                if (t_nxt == samp_pt) begin
                    samp_q <= pad_bit;
                end
            end else begin
                presc_q <= presc_q + 1'b1;
            end
        end
    end

    // Registered pad enables and response strobe; reset releases the pads without a clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owr_pull <= '0;
            rsp_vld  <= 1'b0;
            rsp_dat  <= 1'b0;
        end else begin
            owr_pull <= pull_d;
            rsp_vld  <= rsp_vld_d;
            if (rsp_vld_d) begin
                rsp_dat <= rsp_dat_d;
            end
        end
    end

endmodule

// File: tb/tb_onewire_master_rtl.sv
// tb/tb_onewire_master_rtl.sv - scoreboard bench for onewire_master_rtl
module tb_onewire_master_rtl;

    localparam int OWN   = 3;
    localparam int CDR_N = 10;
    localparam int CDR_O = 7;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           req_vld = 1'b0;
    logic           req_rdy;
    logic           req_cmd = 1'b0;
    logic           req_dat = 1'b0;
    logic           req_ovd = 1'b0;
    logic [1:0]     req_sel = 2'd0;
    logic           rsp_vld;
    logic           rsp_dat;
    logic [OWN-1:0] owr_pull;
    logic [OWN-1:0] owr_i;
    logic [OWN-1:0] slave_lo;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int sl_ch   = 0;
    int sl_from = 0;
    int sl_to   = 0;
    int sl_base = 0;

    typedef struct {
        bit dat;
        int at;
    } rsp_t;

    typedef struct {
        int ch;
        int start;
        int len;
    } pul_t;

    rsp_t rq[$];
    pul_t pq[$];

    int  st[OWN];
    bit  hi[OWN];

    onewire_master_rtl #(.OWN(OWN), .CDR_N(CDR_N), .CDR_O(CDR_O)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_vld  (req_vld),
        .req_rdy  (req_rdy),
        .req_cmd  (req_cmd),
        .req_dat  (req_dat),
        .req_ovd  (req_ovd),
        .req_sel  (req_sel),
        .rsp_vld  (rsp_vld),
        .rsp_dat  (rsp_dat),
        .owr_pull (owr_pull),
        .owr_i    (owr_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Wired-AND bus: master or slave can hold a line low
    always_comb begin
        slave_lo = '0;
        if ((cyc - sl_base) >= sl_from && (cyc - sl_base) < sl_to) begin
            slave_lo[sl_ch] = 1'b1;
        end
    end
    assign owr_i = ~(owr_pull | slave_lo);

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor
    always @(negedge clk) begin
        rsp_t e;
        if (!rst && rsp_vld) begin
            if (rq.size() == 0) begin
                chk("rsp_unexpected", 1, 0);
            end else begin
                e = rq.pop_front();
                chk("rsp_dat", int'(rsp_dat), int'(e.dat));
                chk("rsp_cycle", cyc, e.at);
            end
        end
    end

    // Pull monitor: measures each low pulse per channel
    always @(negedge clk) begin
        pul_t e;
        for (int c = 0; c < OWN; c++) begin
            if (rst) begin
                hi[c] = 1'b0;
            end else if (owr_pull[c] && !hi[c]) begin
                hi[c] = 1'b1;
                st[c] = cyc;
            end else if (!owr_pull[c] && hi[c]) begin
                hi[c] = 1'b0;
                if (pq.size() == 0) begin
                    chk("pull_unexpected", c + 1, 0);
                end else begin
                    e = pq.pop_front();
                    chk("pull_ch", c, e.ch);
                    chk("pull_start", st[c], e.start);
                    chk("pull_len", cyc - st[c], e.len);
                end
            end
        end
    end

    // Issue one request; exp_ch < 0 means no pad should move
    task automatic send(input bit cmd, input bit dat, input bit ovd, input logic [1:0] sel,
                        input bit exp_dat, input int exp_ch, input int sfrom, input int sto,
                        input bit hold, input bit exp_rsp);
        int n;
        int cdr;
        int low;
        int fin;
        int acc;
        n   = 0;
        cdr = ovd ? CDR_O : CDR_N;
        low = cmd ? (dat ? 6 : 60) : 480;
        fin = cmd ? 70 : 960;
        @(negedge clk);
        while (!req_rdy && n < 30000) begin
            @(negedge clk);
            n++;
        end
        if (!req_rdy) chk("rdy_timeout", 0, 1);
        req_cmd = cmd;
        req_dat = dat;
        req_ovd = ovd;
        req_sel = sel;
        req_vld = 1'b1;
        acc     = cyc;
        sl_base = acc;
        sl_ch   = int'(sel) % OWN;
        sl_from = sfrom;
        sl_to   = sto;
        if (exp_rsp) rq.push_back('{exp_dat, acc + fin * cdr + 1});
        if (exp_ch >= 0) pq.push_back('{exp_ch, acc + 1, low * cdr});
        @(negedge clk);
        if (!hold) req_vld = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((rq.size() != 0 || pq.size() != 0) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", n < 20000 ? 1 : 0, 1);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("reset_rdy", int'(req_rdy), 1);
        chk("reset_rsp_vld", int'(rsp_vld), 0);
        chk("reset_rsp_dat", int'(rsp_dat), 0);
        chk("reset_pull", int'(owr_pull), 0);
        rst = 1'b0;

        // Presence: slave low during ticks 500..600
        send(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 0, 500 * CDR_N + 1, 600 * CDR_N + 1, 1'b0, 1'b1);
        wait_idle();
        // No device
        send(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 0, 0, 0, 1'b0, 1'b1);
        wait_idle();

        // Write-1 then write-0 back to back
        send(1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 0, 0, 0, 1'b0, 1'b1);
        send(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 0, 0, 0, 1'b0, 1'b1);
        wait_idle();

        // Read slots: slave holds low to tick 30, then releases at tick 3
        send(1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1, 0, 30 * CDR_N + 1, 1'b0, 1'b1);
        wait_idle();
        send(1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 1, 0, 3 * CDR_N + 1, 1'b0, 1'b1);
        wait_idle();

        // Overdrive bit slot on channel 2
        send(1'b1, 1'b1, 1'b1, 2'd2, 1'b1, 2, 0, 0, 1'b0, 1'b1);
        wait_idle();

        // Invalid channel: no pad moves, reset slot reports absent
        send(1'b0, 1'b0, 1'b1, 2'd3, 1'b0, -1, 0, 0, 1'b0, 1'b1);
        wait_idle();

        // req_vld held high through a slot is taken only once
        send(1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 1, 0, 0, 1'b1, 1'b1);
        chk("busy_rdy", int'(req_rdy), 0);
        n = 0;
        while (!rsp_vld && n < 2000) begin
            @(negedge clk);
            n++;
        end
        req_vld = 1'b0;
        chk("hold_timeout", n < 2000 ? 1 : 0, 1);
        wait_idle();
        @(negedge clk);
        chk("hold_rdy_after", int'(req_rdy), 1);

        // Asynchronous abort at tick 200 of a reset slot
        send(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, -1, 0, 0, 1'b0, 1'b0);
        repeat (200 * CDR_N - 2) @(negedge clk);
        chk("pull_before_abort", int'(owr_pull), 1);
        #2 rst = 1'b1;
        #1 chk("abort_pull", int'(owr_pull), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_rdy", int'(req_rdy), 1);
        repeat (9000) @(negedge clk);
        chk("abort_rsp_vld", int'(rsp_vld), 0);
        chk("rsp_left", rq.size(), 0);
        chk("pull_left", pq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/onewire_master_rtl.md
# onewire_master_rtl

Synthesizable, clocked 1-wire bus master that executes reset/presence and single-bit time slots on one of several independent 1-wire channels. It takes commands through a valid/ready request port and returns the presence flag or read bit as a one-cycle response pulse. Normal and overdrive speed are selected per request. It sits between a register/CPU interface, which sequences bytes and ROM commands, and the open-drain pads.

## Interface
- `OWN`, 1: number of 1-wire channels.
- `CDR_N`, 50: clock cycles per timing tick in normal speed (one tick = 1 us at 50 MHz).
- `CDR_O`, 7: clock cycles per timing tick in overdrive speed.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req_vld`  in  1  request valid.
- `req_rdy`  out  1  request ready; high only in IDLE.
- `req_cmd`  in  1  0 = reset/presence slot; 1 = bit slot.
- `req_dat`  in  1  bit to write; 1 also means "read slot".
- `req_ovd`  in  1  1 = overdrive tick (`CDR_O`); 0 = normal tick (`CDR_N`).
- `req_sel`  in  $clog2(OWN) (min 1)  channel index.
- `rsp_vld`  out  1  one-cycle response strobe.
- `rsp_dat`  out  1  presence (reset slot, 1 = device present) or sampled bit (bit slot).
- `owr_pull`  out  OWN  per-channel pull-low enable; the pad drives 0 when set, otherwise Z.
- `owr_i`  in  OWN  per-channel pad input, asynchronous.

## Operation
- FSM states: IDLE, LOW, HIGH.
- IDLE: `req_rdy`=1. On `req_vld`&&`req_rdy`, latch cmd/dat/ovd/sel, clear the prescaler and tick counter `t` (10 bits), and go to LOW.
- Prescaler counts 0..CDR-1. Each wrap produces a tick and increments `t`. CDR is the latched `CDR_O` or `CDR_N`.
- LOW: `owr_pull[sel]`=1 and all other bits 0. Leave LOW when `t` reaches the low limit:
  - reset slot: 480 ticks
  - bit slot with `dat`=0: 60 ticks
  - bit slot with `dat`=1: 6 ticks
- HIGH: `owr_pull`=0. When `t` reaches the sample point, capture the synchronized `owr_i[sel]`:
  - reset slot: sample at tick 550
  - bit slot: sample at tick 15
- End of slot: `t` reaches 960 (reset) or 70 (bit). At that point go to IDLE with `rsp_vld`=1 for one cycle.
  - Reset slot: `rsp_dat` = NOT sampled value.
  - Bit slot: `rsp_dat` = sampled value.
- Write-0 bit slot: the sample at tick 15 falls inside LOW. The sampled value is 0 by construction and is reported as is.
- `owr_i` passes through a 2-flop synchronizer per channel before sampling, so it has 2 cycles of input latency.
- `req_sel` ≥ `OWN`: no channel is pulled and the sample is forced to 1. A reset slot then reports `rsp_dat`=0; a bit slot reports 1. Slot timing is unchanged.
- No response backpressure. The consumer must take `rsp_vld` when it fires.
- The channels are independent pads, but only one slot runs at a time.

## Timing
- Reset values: FSM=IDLE, `req_rdy`=1, `rsp_vld`=0, `rsp_dat`=0, `owr_pull`=0, counters=0, synchronizers=1.
- `rst` is asynchronous. Asserting it mid-slot releases `owr_pull` immediately, with no clock needed. No response is generated for the aborted slot.
- `owr_pull[sel]` rises in the cycle after acceptance (registered output).
- Low phase lasts exactly low-limit × CDR cycles.
- `rsp_vld` fires (ticks_end × CDR) + 1 cycles after the acceptance edge.
  - Normal speed, reset slot, CDR=50: 48001 cycles.
  - Normal speed, bit slot, CDR=50: 3501 cycles.
- In the `rsp_vld` cycle the FSM is already in IDLE and `req_rdy`=1, so back-to-back requests are accepted with no gap.
- The sample is the synchronizer output at the clock edge where `t` reaches the sample point. A pad change must therefore settle ≥2 cycles earlier.
- `req_*` inputs are ignored outside IDLE.

## Test plan
- Reset slot, OWN=1, normal speed, slave model pulls low during ticks 500–600 -> `owr_pull` high 24000 cycles; `rsp_vld` at cycle 48001; `rsp_dat`=1. Repeat with no slave -> `rsp_dat`=0.
- Write-1 then write-0 bit slots back to back, normal speed -> low for 300 cycles, then for 3000 cycles; second slot's `owr_pull` rises the cycle after the first `rsp_vld`; both `rsp_dat` values as specified (1 for idle bus, 0 for write-0).
- Read slot (`dat`=1), slave holds the line low to tick 30 -> `rsp_dat`=0. Slave releases at tick 3 -> `rsp_dat`=1.
- OWN=4, `req_sel`=2, overdrive -> only `owr_pull[2]` toggles; low 6×7=42 cycles; `rsp_vld` at 491 cycles. `req_sel` invalid (OWN=3, sel=3) -> no pull; a reset slot reports `rsp_dat`=0.
- Assert `rst` asynchronously at tick 200 of a reset slot -> `owr_pull`=0 immediately, no `rsp_vld`, `req_rdy`=1 after release. `req_vld` held high during a slot is not accepted until IDLE.
